// File: rtl/matrix_stream_rx.sv
// matrix_stream_rx
// Captures one matrix from an element stream (in_en/in_data with in_end_row
// and in_end framing) into a row-major buffer. It measures the matrix
// dimensions, flags ragged or oversize input, and provides a registered read port.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   in_en, in_data           element strobe and value
//   in_end_row, in_end       end-of-row / end-of-matrix strobes
//   clear                    discard captured matrix and re-arm
//   rd_row, rd_col, rd_data  read index and registered read data (1 cycle)
//   busy, done               capture in progress / complete matrix held
//   rows, cols               stored row count / length of first stored row
//   err_ragged, err_overflow sticky error flags
module matrix_stream_rx #(
  parameter int DATA_W   = 8,
  parameter int MAX_ROWS = 16,
  parameter int MAX_COLS = 16,
  parameter int ROW_W    = 5,
  parameter int COL_W    = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_end_row,
  input  logic              in_end,
  input  logic              clear,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  rows,
  output logic [COL_W-1:0]  cols,
  output logic              err_ragged,
  output logic              err_overflow
);

  localparam int ADDR_W = ROW_W + COL_W;
  // The buffer spans the full address width so indices need no truncation.
  // Only row*MAX_COLS+col locations with in-range row/col are ever touched.
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t            state_q;
  logic [ROW_W-1:0]  row_cnt_q;
  logic [COL_W-1:0]  col_cnt_q;
  logic [COL_W:0]    first_len_q;   // unclipped length of the first row
  logic [ROW_W-1:0]  rows_q;
  logic [COL_W-1:0]  cols_q;
  logic              busy_q;
  logic              done_q;
  logic              ragged_q;
  logic              ovf_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              elem_fits;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;
  logic [COL_W:0]    eff_len;
  logic              row_close;
  logic [COL_W-1:0]  col_cnt_d;
  logic [ROW_W-1:0]  row_cnt_d;
  logic [ROW_W-1:0]  rows_d;
  logic [COL_W-1:0]  first_cols_d;

  // Stream inputs matter only while not holding a finished matrix; clear wins.
  assign accept    = (state_q != S_DONE) && !clear;
  assign elem_fits = (col_cnt_q < COL_W'(MAX_COLS)) && (row_cnt_q < ROW_W'(MAX_ROWS));
  assign wr_en     = accept && in_en && elem_fits;
  assign wr_addr   = ADDR_W'(row_cnt_q) * ADDR_W'(MAX_COLS) + ADDR_W'(col_cnt_q);

  // Row length counts an element arriving in the same cycle as the close.
  assign eff_len   = {1'b0, col_cnt_q} + {{COL_W{1'b0}}, in_en};
  assign row_close = accept && (in_end_row || in_end) && (eff_len != '0);

  assign col_cnt_d    = (col_cnt_q == '1) ? col_cnt_q : col_cnt_q + COL_W'(1);
  assign row_cnt_d    = (row_cnt_q == '1) ? row_cnt_q : row_cnt_q + ROW_W'(1);
  assign rows_d       = (row_cnt_d > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : row_cnt_d;
  assign first_cols_d = (eff_len > (COL_W+1)'(MAX_COLS)) ? COL_W'(MAX_COLS)
                                                         : eff_len[COL_W-1:0];

  assign rd_in_range = (rd_row < ROW_W'(MAX_ROWS)) && (rd_col < COL_W'(MAX_COLS));
  assign rd_addr     = ADDR_W'(rd_row) * ADDR_W'(MAX_COLS) + ADDR_W'(rd_col);

  // Buffer write port; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      first_len_q <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ragged_q    <= 1'b0;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      // Registered read sees the pre-write value on an address collision.
      rd_data_q <= rd_in_range ? mem[rd_addr] : '0;

      if (clear) begin
        state_q     <= S_IDLE;
        row_cnt_q   <= '0;
        col_cnt_q   <= '0;
        first_len_q <= '0;
        rows_q      <= '0;
        cols_q      <= '0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        ragged_q    <= 1'b0;
        ovf_q       <= 1'b0;
      end else if (state_q != S_DONE) begin
        // Order within a cycle: element, then row close, then matrix end.
        if (in_en) begin
          col_cnt_q <= col_cnt_d;
          if (!elem_fits) begin
            ovf_q <= 1'b1;
          end
        end

        if (row_close) begin
          if (row_cnt_q == '0) begin
            cols_q      <= first_cols_d;
            first_len_q <= eff_len;
          end else if (eff_len != first_len_q) begin
            ragged_q <= 1'b1;
          end
          if (row_cnt_q >= ROW_W'(MAX_ROWS)) begin
            ovf_q <= 1'b1;
          end
          row_cnt_q <= row_cnt_d;
          rows_q    <= rows_d;
          col_cnt_q <= '0;   // overrides the element increment above
        end

        if (in_end) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else if (in_en) begin
          state_q <= S_CAPTURE;
          busy_q  <= 1'b1;
        end
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rows         = rows_q;
  assign cols         = cols_q;
  assign err_ragged   = ragged_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_matrix_stream_rx.sv
// tb_matrix_stream_rx
// Randomized and directed matrices are streamed into matrix_stream_rx.
// Expected dimensions, flags and buffer contents are derived from the
// matrix description (row lengths + values), not from cycle behaviour.
module tb_matrix_stream_rx;

  localparam int DATA_W = 8;
  localparam int MR     = 16;
  localparam int MC     = 16;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 5;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_en;
  logic [DATA_W-1:0] in_data;
  logic              in_end_row;
  logic              in_end;
  logic              clear;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [ROW_W-1:0]  rows;
  logic [COL_W-1:0]  cols;
  logic              err_ragged;
  logic              err_overflow;

  matrix_stream_rx #(
    .DATA_W(DATA_W), .MAX_ROWS(MR), .MAX_COLS(MC), .ROW_W(ROW_W), .COL_W(COL_W)
  ) dut (
    .clk(clk), .resetn(resetn), .in_en(in_en), .in_data(in_data),
    .in_end_row(in_end_row), .in_end(in_end), .clear(clear),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .busy(busy), .done(done), .rows(rows), .cols(cols),
    .err_ragged(err_ragged), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Matrix description driven by send_matrix.
  int         nr;
  int         lens [32];
  logic [7:0] mval [32][32];
  bit         co_row, co_end, gaps;

  // Reference model state.
  logic [7:0] exp_mem [MR][MC];
  int         exp_rows, exp_cols;
  bit         exp_ragged, exp_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_en = 0; in_data = '0; in_end_row = 0; in_end = 0; clear = 0;
  endtask

  task automatic check_read(input int r, input int c, input logic [31:0] exp);
    rd_row = ROW_W'(r);
    rd_col = COL_W'(c);
    tick();
    check_val($sformatf("rd(%0d,%0d)", r, c), rd_data, exp);
  endtask

  // Expected results computed from the matrix shape and values.
  task automatic model_matrix();
    exp_rows   = (nr > MR) ? MR : nr;
    exp_cols   = (lens[0] > MC) ? MC : lens[0];
    exp_ragged = 0;
    exp_ovf    = (nr > MR);
    for (int r = 0; r < nr; r++) begin
      if (lens[r] != lens[0]) exp_ragged = 1;
      if (lens[r] > MC) exp_ovf = 1;
    end
    for (int r = 0; r < exp_rows; r++)
      for (int c = 0; c < lens[r] && c < MC; c++)
        exp_mem[r][c] = mval[r][c];
  endtask

  task automatic send_matrix();
    bit ended = 0;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < lens[r]; c++) begin
        in_en = 1; in_data = mval[r][c];
        if (c == lens[r] - 1 && co_row) begin
          in_end_row = 1;
          if (r == nr - 1 && co_end) begin in_end = 1; ended = 1; end
        end
        tick();
        idle_inputs();
        if (!ended && r == 0 && c == 0) check_val("busy_first", busy, 1);
        if (gaps && ($urandom % 4 == 0)) tick();
      end
      if (!co_row) begin
        in_end_row = 1;
        if (r == nr - 1 && co_end) begin in_end = 1; ended = 1; end
        tick();
        idle_inputs();
      end
      if (!ended) check_val("rows_progress", rows, (r + 1 > MR) ? MR : r + 1);
      if (!ended && gaps && ($urandom % 3 == 0)) begin
        in_end_row = 1;   // empty row, must be ignored
        tick();
        idle_inputs();
      end
    end
    if (!ended) begin
      in_end = 1;
      tick();
      idle_inputs();
    end
  endtask

  task automatic check_result(input string tag);
    check_val({tag, ".done"}, done, 1);
    check_val({tag, ".busy"}, busy, 0);
    check_val({tag, ".rows"}, rows, exp_rows);
    check_val({tag, ".cols"}, cols, exp_cols);
    check_val({tag, ".ragged"}, err_ragged, exp_ragged);
    check_val({tag, ".ovf"}, err_overflow, exp_ovf);
    $display("matrix %s: rows=%0d cols=%0d ragged=%0d ovf=%0d", tag, rows, cols, err_ragged, err_overflow);
  endtask

  task automatic random_reads(input int n);
    for (int k = 0; k < n; k++) begin
      int r = $urandom_range(0, exp_rows - 1);
      int lim = (lens[r] > MC) ? MC : lens[r];
      int c = $urandom_range(0, lim - 1);
      check_read(r, c, exp_mem[r][c]);
    end
    check_read(MR, 0, 0);
    check_read(0, MC + $urandom_range(0, 15), 0);
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    idle_inputs();
    check_val("clr.done", done, 0);
    check_val("clr.busy", busy, 0);
    check_val("clr.rows", rows, 0);
    check_val("clr.cols", cols, 0);
    check_val("clr.ragged", err_ragged, 0);
    check_val("clr.ovf", err_overflow, 0);
  endtask

  task automatic run_matrix(input string tag);
    model_matrix();
    send_matrix();
    check_result(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rd_row = '0; rd_col = '0;
    resetn = 0;
    tick(); tick();
    resetn = 1;
    tick();
    check_val("rst.busy", busy, 0);
    check_val("rst.done", done, 0);
    check_val("rst.rows", rows, 0);
    check_val("rst.cols", cols, 0);
    check_val("rst.ragged", err_ragged, 0);
    check_val("rst.ovf", err_overflow, 0);
    check_val("rst.rd_data", rd_data, 0);

    // 3x3 of 1..9, separate row-close cycles.
    nr = 3; co_row = 0; co_end = 0; gaps = 0;
    for (int r = 0; r < 3; r++) begin lens[r] = 3; for (int c = 0; c < 3; c++) mval[r][c] = 8'(r * 3 + c + 1); end
    run_matrix("3x3");
    check_read(0, 0, 1); check_read(1, 2, 6); check_read(2, 2, 9);
    do_clear();

    // 2x4, row close coincident with element, end coincident with last close.
    nr = 2; co_row = 1; co_end = 1;
    for (int r = 0; r < 2; r++) begin lens[r] = 4; for (int c = 0; c < 4; c++) mval[r][c] = 8'($urandom); end
    run_matrix("2x4");
    check_read(1, 3, mval[1][3]);
    do_clear();

    // Ragged 3,2,3.
    nr = 3; co_row = 0; co_end = 0; lens[0] = 3; lens[1] = 2; lens[2] = 3;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mval[r][c] = 8'($urandom);
    run_matrix("ragged");
    check_read(1, 1, mval[1][1]);
    do_clear();

    // 17 rows of 18: column and row overflow.
    nr = 17; co_row = $urandom % 2; co_end = $urandom % 2;
    for (int r = 0; r < 17; r++) begin lens[r] = 18; for (int c = 0; c < 18; c++) mval[r][c] = 8'($urandom); end
    run_matrix("overflow");
    check_read(0, 15, mval[0][15]);
    check_read(15, 15, mval[15][15]);
    do_clear();

    // Reset mid-capture, then 1x2 {7,8}.
    for (int k = 0; k < 5; k++) begin in_en = 1; in_data = 8'($urandom); tick(); end
    idle_inputs();
    resetn = 0; tick(); resetn = 1;
    check_val("midrst.busy", busy, 0);
    check_val("midrst.rows", rows, 0);
    nr = 1; lens[0] = 2; mval[0][0] = 7; mval[0][1] = 8; co_row = 0; co_end = 0;
    run_matrix("after_reset");
    check_read(0, 0, 7); check_read(0, 1, 8);

    // DONE ignores the stream.
    in_en = 1; in_data = 8'hFF; in_end_row = 1; in_end = 1;
    tick();
    idle_inputs();
    check_val("hold.rows", rows, 1);
    check_val("hold.cols", cols, 2);
    check_val("hold.done", done, 1);
    check_read(0, 0, 7);

    // Element coincident with clear is dropped; next element lands at (0,0).
    in_en = 1; in_data = 8'h55; clear = 1;
    tick();
    idle_inputs();
    check_val("clr55.done", done, 0);
    check_val("clr55.busy", busy, 0);
    nr = 1; lens[0] = 1; mval[0][0] = 8'hAB; co_row = 1; co_end = 1;
    run_matrix("1x1_after_clear");
    check_read(0, 0, 8'hAB);
    do_clear();

    // in_end in IDLE with no data.
    in_end = 1; tick(); idle_inputs();
    check_val("empty.done", done, 1);
    check_val("empty.rows", rows, 0);
    check_val("empty.cols", cols, 0);
    do_clear();

    // Random matrices.
    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 7);
      int base = $urandom_range(1, 6);
      nr = $urandom_range(1, 4);
      if (kind == 0) begin nr = 17; base = $urandom_range(1, 3); end
      if (kind == 1) base = $urandom_range(16, 18);
      for (int r = 0; r < nr; r++) begin
        lens[r] = base;
        if (kind == 2 && ($urandom % 2 == 1)) lens[r] = $urandom_range(1, 6);
        for (int c = 0; c < lens[r]; c++) mval[r][c] = 8'($urandom);
      end
      co_row = $urandom % 2; co_end = $urandom % 2; gaps = $urandom % 2;
      run_matrix($sformatf("rand%0d", t));
      random_reads(3);
      do_clear();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
